uart_pro_rx_parser: RTL and testbench

// - Sits after the UART receiver. Collects ASCII decimal digit bytes (one per pi_flag strobe).
// - Decodes a 12-digit frame into four 3-digit unsigned values x, y, w, h.
// - x, y, w, h typically form a window/ROI descriptor for downstream video logic.

---
 rtl/uart_pro_rx_parser.sv | 70 +++++++
 tb/tb_uart_pro_rx_parser.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_pro_rx_parser.sv
// Turns 12 ASCII digits into four 3-digit fields x/y/w/h; a non-digit byte aborts the frame.
// Outputs register on the edge that takes the 12th digit. No backpressure: one byte is taken per pi_flag cycle.
module uart_pro_rx_parser (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [9:0] w,
  output logic [9:0] h
);

  logic [3:0] r_cnt;
  logic [9:0] r_acc;
  logic [9:0] r_sx, r_sy, r_sw;
  logic [9:0] r_x, r_y, r_w, r_h;

  logic       w_is_digit;
  logic       w_field_end;
  logic [9:0] w_acc_next;

  assign w_is_digit  = (pi_data >= 8'h30) && (pi_data <= 8'h39);
  assign w_field_end = (r_cnt == 4'd2) || (r_cnt == 4'd5) || (r_cnt == 4'd8) || (r_cnt == 4'd11);
  // For 0x30..0x39 the low nibble equals pi_data - 0x30.
  assign w_acc_next  = (r_acc << 3) + (r_acc << 1) + {6'd0, pi_data[3:0]};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt <= 4'd0;
      r_acc <= 10'd0;
      r_sx  <= 10'd0;
      r_sy  <= 10'd0;
      r_sw  <= 10'd0;
      r_x   <= 10'd0;
      r_y   <= 10'd0;
      r_w   <= 10'd0;
      r_h   <= 10'd0;
    end else if (pi_flag) begin
      if (!w_is_digit) begin
        r_cnt <= 4'd0;
        r_acc <= 10'd0;
      end else if (w_field_end) begin
        r_acc <= 10'd0;
        case (r_cnt)
          4'd2:    r_sx <= w_acc_next;
          4'd5:    r_sy <= w_acc_next;
          4'd8:    r_sw <= w_acc_next;
          default: begin
            // Last field goes straight to h so all four outputs move together.
            r_x <= r_sx;
            r_y <= r_sy;
            r_w <= r_sw;
            r_h <= w_acc_next;
          end
        endcase
        r_cnt <= (r_cnt == 4'd11) ? 4'd0 : r_cnt + 4'd1;
      end else begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign x = r_x;
  assign y = r_y;
  assign w = r_w;
  assign h = r_h;

endmodule

// File: tb/tb_uart_pro_rx_parser.sv
// Directed bench for uart_pro_rx_parser: frames, abort, mid-frame reset, idle data and held strobe.
module tb_uart_pro_rx_parser;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [7:0] pi_data;
  logic       pi_flag;
  logic [9:0] x, y, w, h;

  int n_checks = 0;
  int n_fail   = 0;

  uart_pro_rx_parser dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pi_data   (pi_data),
    .pi_flag   (pi_flag),
    .x         (x),
    .y         (y),
    .w         (w),
    .h         (h)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  task automatic send_byte(input logic [7:0] b);
    @(negedge sys_clk);
    pi_data = b;
    pi_flag = 1'b1;
    @(negedge sys_clk);
    pi_flag = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    pi_flag   = 1'b0;
    pi_data   = 8'h00;
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if ({x, y, w, h} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_active: got x=%0d y=%0d w=%0d h=%0d, want all 0", x, y, w, h);
    end
    sys_rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    n_checks++;
    if ({x, y, w, h} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got x=%0d y=%0d w=%0d h=%0d, want all 0", x, y, w, h);
    end
  endtask

  task automatic test_first_frame();
    string s = "640480001234";
    for (int i = 0; i < 12; i++) begin
      send_byte(8'(s[i]));
      if (i < 11) begin
        n_checks++;
        if ({x, y, w, h} !== 40'd0) begin
          n_fail++;
          $display("FAIL frame1_hold[%0d]: got x=%0d y=%0d w=%0d h=%0d, want all 0", i, x, y, w, h);
        end
      end
    end
    n_checks++;
    if (x !== 10'd640 || y !== 10'd480 || w !== 10'd1 || h !== 10'd234) begin
      n_fail++;
      $display("FAIL frame1: got x=%0d y=%0d w=%0d h=%0d, want 640 480 1 234", x, y, w, h);
    end
  endtask

  task automatic test_second_frame();
    string s = "999000123045";
    for (int i = 0; i < 12; i++) begin
      send_byte(8'(s[i]));
      if (i < 11) begin
        n_checks++;
        if (x !== 10'd640 || y !== 10'd480 || w !== 10'd1 || h !== 10'd234) begin
          n_fail++;
          $display("FAIL frame2_hold[%0d]: got x=%0d y=%0d w=%0d h=%0d, want 640 480 1 234", i, x, y, w, h);
        end
      end
    end
    n_checks++;
    if (x !== 10'd999 || y !== 10'd0 || w !== 10'd123 || h !== 10'd45) begin
      n_fail++;
      $display("FAIL frame2: got x=%0d y=%0d w=%0d h=%0d, want 999 0 123 45", x, y, w, h);
    end
  endtask

  task automatic test_abort();
    string s = "64048A100200300400";
    for (int i = 0; i < 18; i++) begin
      send_byte(8'(s[i]));
      if (i < 17) begin
        n_checks++;
        if (x !== 10'd999 || y !== 10'd0 || w !== 10'd123 || h !== 10'd45) begin
          n_fail++;
          $display("FAIL abort_hold[%0d]: got x=%0d y=%0d w=%0d h=%0d, want 999 0 123 45", i, x, y, w, h);
        end
      end
    end
    n_checks++;
    if (x !== 10'd100 || y !== 10'd200 || w !== 10'd300 || h !== 10'd400) begin
      n_fail++;
      $display("FAIL abort_frame: got x=%0d y=%0d w=%0d h=%0d, want 100 200 300 400", x, y, w, h);
    end
  endtask

  task automatic test_reset_mid_frame();
    string p = "1234567";
    string s = "010020030040";
    for (int i = 0; i < 7; i++) send_byte(8'(p[i]));
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({x, y, w, h} !== 40'd0) begin
      n_fail++;
      $display("FAIL midreset_async: got x=%0d y=%0d w=%0d h=%0d, want all 0", x, y, w, h);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    n_checks++;
    if ({x, y, w, h} !== 40'd0) begin
      n_fail++;
      $display("FAIL midreset_after: got x=%0d y=%0d w=%0d h=%0d, want all 0", x, y, w, h);
    end
    for (int i = 0; i < 12; i++) send_byte(8'(s[i]));
    n_checks++;
    if (x !== 10'd10 || y !== 10'd20 || w !== 10'd30 || h !== 10'd40) begin
      n_fail++;
      $display("FAIL midreset_frame: got x=%0d y=%0d w=%0d h=%0d, want 10 20 30 40", x, y, w, h);
    end
  endtask

  task automatic test_flag_low_and_hold();
    string s = "666777888";
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      pi_data = 8'h30 + 8'(i % 10);
    end
    @(negedge sys_clk);
    n_checks++;
    if (x !== 10'd10 || y !== 10'd20 || w !== 10'd30 || h !== 10'd40) begin
      n_fail++;
      $display("FAIL flag_low: got x=%0d y=%0d w=%0d h=%0d, want 10 20 30 40", x, y, w, h);
    end
    pi_data = 8'h35;
    pi_flag = 1'b1;
    repeat (3) @(negedge sys_clk);
    pi_flag = 1'b0;
    repeat (2) @(negedge sys_clk);
    for (int i = 0; i < 9; i++) send_byte(8'(s[i]));
    n_checks++;
    if (x !== 10'd555 || y !== 10'd666 || w !== 10'd777 || h !== 10'd888) begin
      n_fail++;
      $display("FAIL flag_hold: got x=%0d y=%0d w=%0d h=%0d, want 555 666 777 888", x, y, w, h);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_second_frame();
    test_abort();
    test_reset_mid_frame();
    test_flag_low_and_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
